// File: rtl/quad_warp_raster.sv
// quad_warp_raster
//   Rasterises one warp of WARP_WIDTH horizontally adjacent pixels against a
//   convex polygon of NUM_VERTS vertices. One polygon edge is evaluated per
//   clock for every pixel of the warp in parallel. The per-edge pass masks are
//   ANDed into an accumulator. The coverage mask is published once all edges
//   have been folded in.
//
// Ports
//   Clk       rising-edge clock
//   Reset_n   asynchronous active-low reset
//   start     request pulse, accepted only while idle
//   vertices  vertex list, [e][0] = x, [e][1] = y, edge e runs v[e] -> v[e+1]
//   drawY     scanline y
//   warpX     x of the first pixel in the warp
//   orient    0: inside when all edge values >= 0, 1: inside when all <= 0
//   busy      high from the cycle after acceptance until done
//   done      one-cycle pulse when isInside updates
//   isInside  bit k = coverage of pixel (warpX+k, drawY)
module quad_warp_raster #(
  parameter int WARP_WIDTH = 240,
  parameter int NUM_VERTS  = 4,
  parameter int COORD_W    = 10
) (
  input  logic                                    Clk,
  input  logic                                    Reset_n,
  input  logic                                    start,
  input  logic [NUM_VERTS-1:0][1:0][COORD_W-1:0]  vertices,
  input  logic [COORD_W-1:0]                      drawY,
  input  logic [COORD_W-1:0]                      warpX,
  input  logic                                    orient,
  output logic                                    busy,
  output logic                                    done,
  output logic [WARP_WIDTH-1:0]                   isInside
);

  // Wide enough that (px-xa)*(yb-ya) - (py-ya)*(xb-xa) can never overflow,
  // with px reaching up to 2^(COORD_W+1)-1.
  localparam int EW    = 2*COORD_W + 6;
  localparam int CNT_W = (NUM_VERTS > 1) ? $clog2(NUM_VERTS) : 1;

  typedef enum logic [1:0] {IDLE, EDGE, DONE} state_t;

  state_t                                  state;
  logic [CNT_W-1:0]                        cnt;
  logic [CNT_W-1:0]                        nxt;
  logic [WARP_WIDTH-1:0]                   acc_p1;
  logic [WARP_WIDTH-1:0]                   pass_mask;

  logic [NUM_VERTS-1:0][1:0][COORD_W-1:0]  vert_p0;
  logic [COORD_W-1:0]                      drawy_p0;
  logic [COORD_W-1:0]                      warpx_p0;
  logic                                    orient_p0;

  logic signed [EW-1:0]                    xa, ya, xb, yb, py, px_base;

  // Signed edge function of pixel (px,py) against directed edge a->b.
  function automatic logic signed [EW-1:0] edge_val(
    input logic signed [EW-1:0] px,
    input logic signed [EW-1:0] py_i,
    input logic signed [EW-1:0] xa_i,
    input logic signed [EW-1:0] ya_i,
    input logic signed [EW-1:0] xb_i,
    input logic signed [EW-1:0] yb_i
  );
    return (px - xa_i) * (yb_i - ya_i) - (py_i - ya_i) * (xb_i - xa_i);
  endfunction

  // Inclusive side test: zero passes for either orientation, so pixels on an
  // edge are covered and a degenerate edge (a==b, E==0) excludes nothing.
  function automatic logic edge_pass(
    input logic signed [EW-1:0] e,
    input logic                 orn
  );
    logic is_zero;
    is_zero = (e == '0);
    return orn ? (e[EW-1] || is_zero) : !e[EW-1];
  endfunction

  // ---- stage p0: job capture on acceptance ----
  // Data registers need no reset; they are only read while a job is active.
  always_ff @(posedge Clk) begin
    if (state == IDLE && start) begin
      vert_p0   <= vertices;
      drawy_p0  <= drawY;
      warpx_p0  <= warpX;
      orient_p0 <= orient;
    end
  end

  always_comb begin
    nxt = (cnt == CNT_W'(NUM_VERTS-1)) ? '0 : cnt + CNT_W'(1);
  end

  // ---- stage p1: one edge against every pixel of the warp ----
  always_comb begin
    xa        = EW'(vert_p0[cnt][0]);
    ya        = EW'(vert_p0[cnt][1]);
    xb        = EW'(vert_p0[nxt][0]);
    yb        = EW'(vert_p0[nxt][1]);
    py        = EW'(drawy_p0);
    px_base   = EW'(warpx_p0);
    pass_mask = '0;
    for (int k = 0; k < WARP_WIDTH; k++) begin
      pass_mask[k] = edge_pass(edge_val(px_base + EW'(k), py, xa, ya, xb, yb),
                               orient_p0);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_p1   <= '1;
      busy     <= 1'b0;
      done     <= 1'b0;
      isInside <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= EDGE;
            cnt    <= '0;
            acc_p1 <= '1;
            busy   <= 1'b1;
          end
        end
        EDGE: begin
          acc_p1 <= acc_p1 & pass_mask;
          if (cnt == CNT_W'(NUM_VERTS-1)) begin
            // Publish the final mask together with entry into DONE so that
            // done and isInside are visible in the same cycle.
            state    <= DONE;
            cnt      <= '0;
            done     <= 1'b1;
            isInside <= acc_p1 & pass_mask;
          end else begin
            cnt <= nxt;
          end
        end
        DONE: begin
          // Any start seen here is dropped; the next acceptance is from IDLE.
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quad_warp_raster.sv
module tb_quad_warp_raster;

  typedef logic [3:0][1:0][9:0] vert_t;

  typedef struct {
    bit           t3;
    vert_t        v;
    int           dy;
    int           wx;
    bit           ori;
    logic [239:0] exp;
  } vec_t;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          start4, start3;
  vert_t         verts;
  logic [9:0]    drawY, warpX;
  logic          orient;
  logic          busy4, done4, busy3, done3;
  logic [239:0]  ins4;
  logic [63:0]   ins3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  quad_warp_raster dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start4), .vertices(verts),
    .drawY(drawY), .warpX(warpX), .orient(orient),
    .busy(busy4), .done(done4), .isInside(ins4)
  );

  quad_warp_raster #(.WARP_WIDTH(64), .NUM_VERTS(3), .COORD_W(10)) dut3 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start3), .vertices(verts[2:0]),
    .drawY(drawY), .warpX(warpX), .orient(orient),
    .busy(busy3), .done(done3), .isInside(ins3)
  );

  task automatic chk(input string nm, input logic [239:0] got, input logic [239:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic vert_t mkv(input int x0, input int y0, input int x1, input int y1,
                                input int x2, input int y2, input int x3, input int y3);
    vert_t v;
    v[0][0] = 10'(x0); v[0][1] = 10'(y0);
    v[1][0] = 10'(x1); v[1][1] = 10'(y1);
    v[2][0] = 10'(x2); v[2][1] = 10'(y2);
    v[3][0] = 10'(x3); v[3][1] = 10'(y3);
    return v;
  endfunction

  function automatic vert_t rand_verts(input int maxc);
    vert_t v;
    for (int e = 0; e < 4; e++) begin
      v[e][0] = 10'($urandom_range(0, maxc));
      v[e][1] = 10'($urandom_range(0, maxc));
    end
    return v;
  endfunction

  function automatic logic [239:0] range_mask(input int lo, input int hi);
    logic [239:0] m;
    m = '0;
    for (int k = lo; k <= hi; k++) m[k] = 1'b1;
    return m;
  endfunction

  // Coverage straight from the edge-function definition: a pixel is inside
  // when it lies on the correct side of (or on) every edge.
  function automatic logic [239:0] model(input vert_t v, input int n, input int w,
                                         input int dy, input int wx, input bit ori);
    logic [239:0] m;
    longint       e;
    int           xa, ya, xb, yb, b;
    bit           in;
    m = '0;
    for (int k = 0; k < w; k++) begin
      in = 1'b1;
      for (int i = 0; i < n; i++) begin
        b  = (i + 1) % n;
        xa = int'(v[i][0]); ya = int'(v[i][1]);
        xb = int'(v[b][0]); yb = int'(v[b][1]);
        e  = longint'(wx + k - xa) * longint'(yb - ya)
           - longint'(dy - ya) * longint'(xb - xa);
        if (ori ? (e > 0) : (e < 0)) in = 1'b0;
      end
      m[k] = in;
    end
    return m;
  endfunction

  function automatic logic [239:0] outs(input bit t3);
    return t3 ? 240'(ins3) : ins4;
  endfunction

  // One job: apply inputs, pulse start, scramble inputs during the job, then
  // check busy/done every cycle and the mask on the done cycle.
  task automatic run_job(input bit t3, input vert_t v, input int dy, input int wx,
                         input bit ori, input logic [239:0] exp, input string nm);
    int n;
    n = t3 ? 3 : 4;
    @(negedge Clk);
    verts = v; drawY = 10'(dy); warpX = 10'(wx); orient = ori;
    if (t3) start3 = 1'b1; else start4 = 1'b1;
    @(posedge Clk);
    #1;
    start3 = 1'b0; start4 = 1'b0;
    verts = rand_verts(1023); drawY = 10'($urandom); warpX = 10'($urandom); orient = ~ori;
    for (int j = 0; j <= n + 1; j++) begin
      @(negedge Clk);
      chk($sformatf("%s_busy_c%0d", nm, j), 240'(t3 ? busy3 : busy4), 240'(j <= n));
      chk($sformatf("%s_done_c%0d", nm, j), 240'(t3 ? done3 : done4), 240'(j == n));
      if (j == n) chk($sformatf("%s_mask", nm), outs(t3), exp);
    end
  endtask

  vec_t         tbl [5];
  vert_t        quad, trig, vb;
  logic [239:0] ea, eb;
  bit           rt3, rori;
  int           rdy, rwx;

  initial begin
    Reset_n = 1'b0; start4 = 1'b0; start3 = 1'b0;
    verts = '0; drawY = '0; warpX = '0; orient = 1'b0;
    #2;
    chk("rst_busy4", 240'(busy4), 240'(0));
    chk("rst_done4", 240'(done4), 240'(0));
    chk("rst_ins4",  ins4, 240'(0));
    chk("rst_busy3", 240'(busy3), 240'(0));
    chk("rst_done3", 240'(done3), 240'(0));
    chk("rst_ins3",  240'(ins3), 240'(0));
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;

    quad = mkv(300, 200, 20, 200, 20, 20, 200, 20);
    trig = mkv(0, 0, 100, 0, 0, 100, 0, 0);
    tbl[0] = '{1'b0, quad, 110, 16, 1'b1, range_mask(4, 234)};
    tbl[1] = '{1'b0, quad, 110, 16, 1'b0, 240'(0)};
    tbl[2] = '{1'b0, quad, 10,  16, 1'b1, 240'(0)};
    tbl[3] = '{1'b0, quad, 200, 0,  1'b1, range_mask(20, 239)};
    tbl[4] = '{1'b1, trig, 40,  0,  1'b1, range_mask(0, 60)};
    for (int i = 0; i < 5; i++)
      run_job(tbl[i].t3, tbl[i].v, tbl[i].dy, tbl[i].wx, tbl[i].ori, tbl[i].exp,
              $sformatf("vec%0d", i));

    // Restarts during EDGE are dropped: one done carrying the first job.
    ea = range_mask(4, 234);
    @(negedge Clk);
    verts = quad; drawY = 10'(110); warpX = 10'(16); orient = 1'b1; start4 = 1'b1;
    @(posedge Clk);
    #1;
    start4 = 1'b0;
    for (int j = 0; j <= 10; j++) begin
      @(negedge Clk);
      chk($sformatf("retrig_busy_c%0d", j), 240'(busy4), 240'(j <= 4));
      chk($sformatf("retrig_done_c%0d", j), 240'(done4), 240'(j == 4));
      if (j == 4) chk("retrig_mask", ins4, ea);
      if (j <= 1) begin
        verts = rand_verts(1023); drawY = 10'($urandom); orient = 1'b0; start4 = 1'b1;
      end else begin
        start4 = 1'b0;
      end
    end

    // start held through DONE: ignored there, accepted the following cycle.
    vb = mkv(0, 0, 500, 0, 500, 500, 0, 500);
    eb = model(vb, 4, 240, 250, 300, 1'b0);
    @(negedge Clk);
    verts = quad; drawY = 10'(110); warpX = 10'(16); orient = 1'b1; start4 = 1'b1;
    @(posedge Clk);
    #1;
    verts = vb; drawY = 10'(250); warpX = 10'(300); orient = 1'b0;
    for (int j = 0; j <= 13; j++) begin
      @(negedge Clk);
      chk($sformatf("hold_busy_c%0d", j), 240'(busy4), 240'((j <= 4) || (j >= 6 && j <= 10)));
      chk($sformatf("hold_done_c%0d", j), 240'(done4), 240'(j == 4 || j == 10));
      if (j == 4)  chk("hold_mask_a", ins4, ea);
      if (j == 10) chk("hold_mask_b", ins4, eb);
      if (j >= 6) start4 = 1'b0;
    end

    // Mid-job reset: outputs clear at once, no late done, restart works.
    run_job(1'b0, quad, 110, 16, 1'b1, ea, "pre_rst");
    @(negedge Clk);
    chk("hold_isinside", ins4, ea);
    verts = quad; drawY = 10'(110); warpX = 10'(16); orient = 1'b1; start4 = 1'b1;
    @(posedge Clk);
    #1;
    start4 = 1'b0;
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_busy", 240'(busy4), 240'(0));
    chk("arst_done", 240'(done4), 240'(0));
    chk("arst_ins",  ins4, 240'(0));
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge Clk);
      chk($sformatf("post_rst_done_c%0d", j), 240'(done4), 240'(0));
      chk($sformatf("post_rst_busy_c%0d", j), 240'(busy4), 240'(0));
    end
    run_job(1'b0, quad, 200, 0, 1'b1, range_mask(20, 239), "after_rst");

    // Randomised jobs against the reference model.
    for (int i = 0; i < 24; i++) begin
      rt3  = (i % 4 == 3);
      vb   = rand_verts(400);
      rdy  = int'($urandom_range(0, 400));
      rwx  = int'($urandom_range(0, 300));
      rori = 1'($urandom);
      eb   = model(vb, rt3 ? 3 : 4, rt3 ? 64 : 240, rdy, rwx, rori);
      run_job(rt3, vb, rdy, rwx, rori, eb, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
